// File: rtl/ext_ins_bridge_if.sv
// Fetch-side and external-bus signals of the instruction fetch bridge.
// "master" is the bridge view; "slave" is the fetch stage plus bus environment.
interface ext_ins_bridge_if;
  logic        ins_ren;
  logic [31:0] ins_addr;
  logic        flush;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        err_clr;
  logic        err_flag;

  modport master (
    input  ins_ren, ins_addr, flush, bus_gnt, bus_rvalid, bus_rdata, bus_err, err_clr,
    output ins_valid, ins_data, bus_req, bus_addr, err_flag
  );

  modport slave (
    output ins_ren, ins_addr, flush, bus_gnt, bus_rvalid, bus_rdata, bus_err, err_clr,
    input  ins_valid, ins_data, bus_req, bus_addr, err_flag
  );
endinterface

// File: rtl/ext_ins_bridge.sv
// External instruction fetch bridge: one-entry line buffer in front of a
// req/gnt/rvalid read bus, with timeout, error substitution and flush.
module ext_ins_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input logic              clk,
  input logic              nrst,
  ext_ins_bridge_if.master bif
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e        state_q;
  logic          buf_vld_q;
  logic [29:0]   buf_tag_q;
  logic [31:0]   buf_data_q;
  logic [29:0]   req_addr_q;
  logic          bus_req_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          hit;
  logic          abort;
  logic          in_wait;
  logic          rsp_ok;
  logic          rsp_err;
  logic          tmo;
  logic          start;
  logic [CW-1:0] cnt_inc;

  assign hit     = (state_q == IDLE) && bif.ins_ren && buf_vld_q &&
                   (bif.ins_addr[31:2] == buf_tag_q);
  // Redirect or fetch address moving away from the outstanding request.
  assign abort   = bif.flush || (bif.ins_addr[31:2] != req_addr_q);
  assign in_wait = (state_q == WAIT);
  assign rsp_ok  = in_wait && bif.bus_rvalid && !bif.bus_err && !abort;
  assign rsp_err = in_wait && bif.bus_rvalid &&  bif.bus_err && !abort;
  assign cnt_inc = cnt_q + 1'b1;
  // Fires on the TIMEOUT-th WAIT cycle without a response.
  assign tmo     = in_wait && !bif.bus_rvalid && !abort && (cnt_inc == CW'(TIMEOUT));
  assign start   = (state_q == IDLE) && bif.ins_ren && !hit && !bif.flush;

  assign bif.ins_valid = hit || rsp_ok || rsp_err || tmo;
  assign bif.ins_data  = hit    ? buf_data_q    :
                         rsp_ok ? bif.bus_rdata : NOP_INS;
  assign bif.bus_req   = bus_req_q;
  assign bif.bus_addr  = {req_addr_q, 2'b00};
  assign bif.err_flag  = err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      buf_vld_q  <= 1'b0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
      req_addr_q <= '0;
      bus_req_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (bif.flush) buf_vld_q <= 1'b0;
      if (rsp_ok) begin
        buf_vld_q  <= 1'b1;
        buf_tag_q  <= req_addr_q;
        buf_data_q <= bif.bus_rdata;
      end

      if (rsp_err || tmo)   err_q <= 1'b1;
      else if (bif.err_clr) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            req_addr_q <= bif.ins_addr[31:2];
            bus_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // A grant coinciding with an abort still owes us a response.
          if (abort) begin
            bus_req_q <= 1'b0;
            state_q   <= bif.bus_gnt ? DROP : IDLE;
          end else if (bif.bus_gnt) begin
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (abort)               state_q <= bif.bus_rvalid ? IDLE : DROP;
          else if (bif.bus_rvalid) state_q <= IDLE;
          else if (tmo)            state_q <= DROP;
          else                     cnt_q   <= cnt_inc;
        end
        DROP: begin
          if (bif.bus_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_ins_bridge.sv
// Randomized bench for ext_ins_bridge against a transaction-level model of
// the line buffer and sticky error flag.
module tb_ext_ins_bridge;
  localparam int          TMO = 16;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  ext_ins_bridge_if bif();
  ext_ins_bridge #(.TIMEOUT(TMO), .NOP_INS(NOP)) dut (.clk(clk), .nrst(nrst), .bif(bif));

  int checks = 0;
  int errors = 0;

  // reference state
  logic        mb_vld = 1'b0;
  logic [29:0] mb_tag = '0;
  logic [31:0] mb_data = '0;
  logic        merr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic smp(); @(negedge clk); endtask
  task automatic adv(); @(posedge clk); #1; endtask

  task automatic quiet();
    bif.ins_ren = 1'b0; bif.flush = 1'b0; bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
    bif.bus_err = 1'b0; bif.bus_rdata = '0; bif.err_clr = 1'b0;
  endtask

  task automatic idle(input bit clr);
    quiet();
    bif.err_clr = clr;
    smp();
    chk("idle_vld", bif.ins_valid, 0);
    chk("idle_req", bif.bus_req, 0);
    chk("idle_err", bif.err_flag, merr);
    adv();
    if (clr) merr = 1'b0;
  endtask

  // outstanding response must be swallowed: nothing reaches the fetch stage
  task automatic drop();
    int n;
    n = $urandom_range(0, 3);
    bif.flush = 1'b0; bif.bus_gnt = 1'b0;
    for (int i = 0; i <= n; i++) begin
      bif.ins_ren    = 1'($urandom_range(0, 1));
      bif.bus_rvalid = (i == n);
      bif.bus_err    = 1'($urandom_range(0, 1));
      bif.bus_rdata  = $urandom;
      smp();
      chk("drop_vld", bif.ins_valid, 0);
      chk("drop_req", bif.bus_req, 0);
      adv();
    end
  endtask

  // kind: 0 ok, 1 bus error, 2 timeout, 3 flush in WAIT, 4 addr change in WAIT, 5 reset in WAIT
  task automatic fetch(input logic [31:0] a, input int kind, input int gd, input int rd,
                       input logic [31:0] rdat, input bit same);
    logic hit;
    int   nw;
    quiet();
    bif.ins_ren  = 1'b1;
    bif.ins_addr = a;
    hit = mb_vld && (a[31:2] == mb_tag);
    smp();
    chk("err_flag", bif.err_flag, merr);
    chk("first_vld", bif.ins_valid, hit);
    chk("first_req", bif.bus_req, 0);
    chk("first_data", bif.ins_data, hit ? mb_data : NOP);
    adv();
    if (hit) return;

    for (int i = 0; i <= gd; i++) begin
      bif.ins_ren = 1'($urandom_range(0, 1));
      bif.bus_gnt = (i == gd);
      smp();
      chk("req", bif.bus_req, 1);
      chk("req_addr", bif.bus_addr, {a[31:2], 2'b00});
      chk("req_vld", bif.ins_valid, 0);
      adv();
    end
    bif.bus_gnt = 1'b0;

    nw = (kind == 2) ? TMO - 1 : rd;
    for (int j = 0; j < nw; j++) begin
      bif.ins_ren = 1'($urandom_range(0, 1));
      smp();
      chk("wait_req", bif.bus_req, 0);
      chk("wait_vld", bif.ins_valid, 0);
      adv();
    end

    case (kind)
      0, 1: begin
        bif.bus_rvalid = 1'b1;
        bif.bus_err    = (kind == 1);
        bif.bus_rdata  = rdat;
        bif.err_clr    = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        smp();
        chk("rsp_vld", bif.ins_valid, 1);
        chk("rsp_data", bif.ins_data, (kind == 1) ? NOP : rdat);
        adv();
        if (kind == 0) begin
          mb_vld = 1'b1; mb_tag = a[31:2]; mb_data = rdat;
          if (bif.err_clr) merr = 1'b0;
        end else merr = 1'b1;
      end
      2: begin
        smp();
        chk("tmo_vld", bif.ins_valid, 1);
        chk("tmo_data", bif.ins_data, NOP);
        adv();
        merr = 1'b1;
        drop();
      end
      3, 4: begin
        if (kind == 3) bif.flush = 1'b1;
        else           bif.ins_addr = a ^ 32'h0000_0100;
        bif.bus_rvalid = same;
        bif.bus_rdata  = rdat;
        smp();
        chk("abort_vld", bif.ins_valid, 0);
        chk("abort_data", bif.ins_data, NOP);
        adv();
        if (kind == 3) mb_vld = 1'b0;
        bif.bus_rvalid = 1'b0;
        if (!same) drop();
      end
      default: begin
        #2 nrst = 1'b0;
        #1;
        chk("rst_vld", bif.ins_valid, 0);
        chk("rst_req", bif.bus_req, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_err", bif.err_flag, 0);
        mb_vld = 1'b0; merr = 1'b0;
        adv(); adv();
        nrst = 1'b1;
        quiet();
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = rdat;
        smp();
        chk("stray_vld", bif.ins_valid, 0);
        adv();
        idle(0);
      end
    endcase
  endtask

  initial begin
    logic [31:0] a;
    int k;
    nrst = 1'b0;
    quiet();
    bif.ins_addr = '0;
    #12;
    chk("reset_vld", bif.ins_valid, 0);
    chk("reset_req", bif.bus_req, 0);
    chk("reset_addr", bif.bus_addr, 0);
    chk("reset_err", bif.err_flag, 0);
    chk("reset_data", bif.ins_data, NOP);
    adv();
    nrst = 1'b1;
    idle(0);

    // miss then same-word hit
    fetch(32'h804, 0, 0, 1, 32'h00500093, 0);
    fetch(32'h806, 0, 0, 0, 0, 0);
    // bus error: NOP, sticky flag, refetch misses
    fetch(32'h808, 1, 1, 2, 32'hCAFE_F00D, 0);
    fetch(32'h808, 0, 0, 0, 32'h0000_1111, 0);
    idle(0);
    idle(1);
    idle(0);
    // timeout then late response ignored
    fetch(32'h80C, 2, 0, 0, 32'hBAD0_BAD0, 0);
    idle(1);
    // flush in WAIT, then new address
    fetch(32'h810, 3, 0, 2, 32'hDEAD_BEEF, 0);
    fetch(32'h808, 0, 0, 0, 32'h0000_2222, 0);
    fetch(32'h910, 3, 1, 0, 32'h0BAD_0BAD, 1);
    fetch(32'h900, 0, 2, 3, 32'h0000_0900, 0);
    fetch(32'h902, 0, 0, 0, 0, 0);
    // reset mid-WAIT with error flag set
    fetch(32'hA00, 1, 0, 0, 32'h1, 0);
    fetch(32'hA04, 5, 0, 2, 32'h5555_AAAA, 0);
    fetch(32'hA04, 0, 0, 0, 32'h0000_0A04, 0);

    for (int t = 0; t < 200; t++) begin
      a = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      if (k == 9)      idle(1'($urandom_range(0, 1)));
      else if (k <= 4) fetch(a, 0, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, 0);
      else             fetch(a, k - 4, $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                             1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
